// File: rtl/byte_unstrip_if.sv
// byte_unstrip_if -- lane-side and serial-side signals of the byte unstriper.
//
//   LANE0..LANE3 : lane words arriving from the striping end
//   DK_0..DK_3   : per-lane data-valid flags; a group is sampled when DK_0=1
//   CLR          : synchronous clear of the sticky ERR / OVF flags
//   D, DK        : reassembled serial word and its valid flag
//   ERR          : sticky flag, a malformed lane group was seen
//   OVF          : sticky flag, a group was dropped because the buffer was full
//   IDLE         : buffer empty and nothing being sent
//
// master: the traffic source / observer; slave: the unstriper itself.
interface byte_unstrip_if #(
    parameter int BITS = 8
);
    logic [BITS-1:0] LANE0;
    logic [BITS-1:0] LANE1;
    logic [BITS-1:0] LANE2;
    logic [BITS-1:0] LANE3;
    logic            DK_0;
    logic            DK_1;
    logic            DK_2;
    logic            DK_3;
    logic            CLR;
    logic [BITS-1:0] D;
    logic            DK;
    logic            ERR;
    logic            OVF;
    logic            IDLE;

    modport master (
        output LANE0, LANE1, LANE2, LANE3,
        output DK_0, DK_1, DK_2, DK_3,
        output CLR,
        input  D, DK, ERR, OVF, IDLE
    );

    modport slave (
        input  LANE0, LANE1, LANE2, LANE3,
        input  DK_0, DK_1, DK_2, DK_3,
        input  CLR,
        output D, DK, ERR, OVF, IDLE
    );
endinterface

// File: rtl/byte_unstrip.sv
// byte_unstrip -- reassembles 4-lane striped groups into a serial word stream.
//
// A lane group is sampled on any rising edge with DK_0=1; its mask
// {DK_3..DK_0} must be contiguous from lane 0 (0001/0011/0111/1111).
// Accepted groups go into a 2-entry FIFO (4 lane words + last-lane index);
// the sender emits one lane word per cycle on D/DK, head lane 0 first.
//
// Ports:
//   CLK     : single clock, rising edge
//   RESET_L : asynchronous active-low reset
//   bus     : byte_unstrip_if.slave (lanes, DK_n, CLR in; D, DK, ERR, OVF, IDLE out)
//
// Parameters: BITS = word width; LANES = lane count (only 4 is supported).
module byte_unstrip #(
    parameter int BITS  = 8,
    parameter int LANES = 4
) (
    input  logic           CLK,
    input  logic           RESET_L,
    byte_unstrip_if.slave  bus
);

    typedef enum logic {
        SEND_IDLE = 1'b0,
        SEND_BUSY = 1'b1
    } send_state_t;

    // ------------------------------------------------------------------
    // Lane input unpacking
    // ------------------------------------------------------------------
    logic [LANES*BITS-1:0] lanes_flat;
    logic [BITS-1:0]       lane_in [LANES];
    logic [LANES-1:0]      mask;

    assign lanes_flat = {bus.LANE3, bus.LANE2, bus.LANE1, bus.LANE0};
    assign mask       = {bus.DK_3, bus.DK_2, bus.DK_1, bus.DK_0};

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane_in
            assign lane_in[gi] = lanes_flat[gi*BITS +: BITS];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Group decode: only contiguous-from-lane-0 masks are legal.
    // A sample with DK_0=0 but some higher DK set is also malformed.
    // ------------------------------------------------------------------
    logic       grp_valid;
    logic       grp_err;
    logic [1:0] grp_last;

    always_comb begin
        grp_valid = 1'b0;
        grp_err   = 1'b0;
        grp_last  = 2'd0;
        if (mask[0]) begin
            case (mask)
                4'b0001: begin grp_valid = 1'b1; grp_last = 2'd0; end
                4'b0011: begin grp_valid = 1'b1; grp_last = 2'd1; end
                4'b0111: begin grp_valid = 1'b1; grp_last = 2'd2; end
                4'b1111: begin grp_valid = 1'b1; grp_last = 2'd3; end
                default: grp_err = 1'b1;
            endcase
        end else if (mask != '0) begin
            grp_err = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // 2-entry FIFO storage (no reset needed; guarded by occupancy)
    // ------------------------------------------------------------------
    logic [BITS-1:0] lane_mem [2][LANES];
    logic [1:0]      last_mem [2];

    logic            wr_ptr_reg;
    logic            rd_ptr_reg;
    logic [1:0]      occ_reg;
    send_state_t     state_reg;
    logic [1:0]      idx_reg;
    logic [BITS-1:0] d_reg;
    logic            dk_reg;
    logic            err_reg;
    logic            ovf_reg;

    logic pop;
    logic wr_en;

    // The head is popped on the edge that emits its last valid lane. A full
    // FIFO can still accept a group on that same edge.
    assign pop   = (occ_reg != 2'd0) && (idx_reg == last_mem[rd_ptr_reg]);
    assign wr_en = grp_valid && ((occ_reg != 2'd2) || pop);

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                lane_mem[wr_ptr_reg][i] <= lane_in[i];
            end
            last_mem[wr_ptr_reg] <= grp_last;
        end
    end

    // ------------------------------------------------------------------
    // Sender FSM, FIFO pointers and sticky flags
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state_reg  <= SEND_IDLE;
            idx_reg    <= 2'd0;
            d_reg      <= '0;
            dk_reg     <= 1'b0;
            err_reg    <= 1'b0;
            ovf_reg    <= 1'b0;
            occ_reg    <= 2'd0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
        end else begin
            // SEND_IDLE with a non-empty FIFO already emits lane 0 on the
            // edge it leaves idle, which gives the one-cycle latency from
            // capture to the first word. idx is always 0 while idle.
            if (occ_reg != 2'd0) begin
                d_reg  <= lane_mem[rd_ptr_reg][idx_reg];
                dk_reg <= 1'b1;
                if (pop) begin
                    rd_ptr_reg <= ~rd_ptr_reg;
                    idx_reg    <= 2'd0;
                    // Keep going without a gap if another group remains,
                    // including one written on this very edge.
                    state_reg  <= ((occ_reg == 2'd2) || wr_en) ? SEND_BUSY : SEND_IDLE;
                end else begin
                    idx_reg   <= idx_reg + 2'd1;
                    state_reg <= SEND_BUSY;
                end
            end else begin
                d_reg     <= '0;
                dk_reg    <= 1'b0;
                idx_reg   <= 2'd0;
                state_reg <= SEND_IDLE;
            end

            if (wr_en) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end

            case ({wr_en, pop})
                2'b10:   occ_reg <= occ_reg + 2'd1;
                2'b01:   occ_reg <= occ_reg - 2'd1;
                default: occ_reg <= occ_reg;
            endcase

            // CLR wins over a same-edge set.
            if (bus.CLR) begin
                err_reg <= 1'b0;
                ovf_reg <= 1'b0;
            end else begin
                if (grp_err) begin
                    err_reg <= 1'b1;
                end
                if (grp_valid && !wr_en) begin
                    ovf_reg <= 1'b1;
                end
            end
        end
    end

    assign bus.D    = d_reg;
    assign bus.DK   = dk_reg;
    assign bus.ERR  = err_reg;
    assign bus.OVF  = ovf_reg;
    assign bus.IDLE = (state_reg == SEND_IDLE) && (occ_reg == 2'd0);

endmodule

// File: tb/tb_byte_unstrip.sv
// tb_byte_unstrip -- randomized self-checking bench for byte_unstrip.
// A queue-of-groups reference model predicts D/DK/ERR/OVF/IDLE every cycle.
module tb_byte_unstrip;

    logic clk;
    logic rst_n;

    byte_unstrip_if #(.BITS(8)) bus ();

    byte_unstrip #(
        .BITS  (8),
        .LANES (4)
    ) dut (
        .CLK     (clk),
        .RESET_L (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: queue of pending groups and a read position
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] data;
        int          cnt;
    } grp_t;

    grp_t        q[$];
    int          pos;
    logic [7:0]  exp_d;
    logic        exp_dk;
    logic        exp_err;
    logic        exp_ovf;
    logic        exp_idle;

    int n_checks = 0;
    int n_errors = 0;
    int dk_words = 0;

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        pos      = 0;
        exp_d    = 8'h00;
        exp_dk   = 1'b0;
        exp_err  = 1'b0;
        exp_ovf  = 1'b0;
        exp_idle = 1'b1;
    endtask

    task automatic model_edge(input logic [31:0] data, input logic [3:0] m, input logic clr);
        bit popped = 0;
        bit bad    = 0;
        bit good   = 0;
        bit drop   = 0;
        int n;
        // sender: one word per cycle from the head group
        if (q.size() > 0) begin
            exp_d  = q[0].data[8*pos +: 8];
            exp_dk = 1'b1;
            if (pos == q[0].cnt - 1) begin
                popped = 1;
                pos    = 0;
            end else begin
                pos++;
            end
        end else begin
            exp_d  = 8'h00;
            exp_dk = 1'b0;
        end
        // classify the sample: legal when mask == 2^n - 1 with n >= 1
        n = $countones(m);
        if (m[0]) begin
            if (int'(m) == (1 << n) - 1) good = 1;
            else bad = 1;
        end else if (m != 4'b0000) begin
            bad = 1;
        end
        if (popped) void'(q.pop_front());
        if (good) begin
            if (q.size() < 2) q.push_back('{data, n});
            else drop = 1;
        end
        exp_err  = clr ? 1'b0 : (exp_err | bad);
        exp_ovf  = clr ? 1'b0 : (exp_ovf | drop);
        exp_idle = (q.size() == 0);
    endtask

    task automatic check_outputs();
        chk("dk",   bus.DK,   exp_dk);
        chk("d",    bus.D,    exp_d);
        chk("err",  bus.ERR,  exp_err);
        chk("ovf",  bus.OVF,  exp_ovf);
        chk("idle", bus.IDLE, exp_idle);
        if (bus.DK) dk_words++;
    endtask

    // One clock: drive inputs, advance model at the edge, check #1 later.
    task automatic cycle(input logic [31:0] data, input logic [3:0] m, input logic clr);
        bus.LANE0 = data[7:0];
        bus.LANE1 = data[15:8];
        bus.LANE2 = data[23:16];
        bus.LANE3 = data[31:24];
        {bus.DK_3, bus.DK_2, bus.DK_1, bus.DK_0} = m;
        bus.CLR = clr;
        if (m != 4'b0000)
            $display("grp mask=%b lanes=%08h clr=%0b t=%0t", m, data, clr, $time);
        @(posedge clk);
        model_edge(data, m, clr);
        #1;
        check_outputs();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(32'h0, 4'b0000, 1'b0);
    endtask

    logic [3:0] legal_masks [4];

    initial begin
        legal_masks[0] = 4'b0001;
        legal_masks[1] = 4'b0011;
        legal_masks[2] = 4'b0111;
        legal_masks[3] = 4'b1111;

        rst_n = 1'b0;
        bus.LANE0 = '0; bus.LANE1 = '0; bus.LANE2 = '0; bus.LANE3 = '0;
        {bus.DK_3, bus.DK_2, bus.DK_1, bus.DK_0} = 4'b0000;
        bus.CLR = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        check_outputs();
        rst_n = 1'b1;

        // single full group, then drain
        cycle(32'h44332211, 4'b1111, 1'b0);
        dk_words = 0;
        idle_cycles(6);
        chk("full_words", dk_words, 4);
        chk("full_idle", bus.IDLE, 1);

        // 8 back-to-back full groups, one every 4 cycles
        dk_words = 0;
        for (int g = 0; g < 8; g++) begin
            cycle($urandom, 4'b1111, 1'b0);
            idle_cycles(3);
        end
        idle_cycles(3);
        chk("b2b_words", dk_words, 32);
        chk("b2b_ovf", bus.OVF, 0);

        // partial tail 0011
        dk_words = 0;
        cycle(32'hFFFF5AA5, 4'b0011, 1'b0);
        idle_cycles(4);
        chk("tail_words", dk_words, 2);

        // overflow: three full groups on consecutive edges
        dk_words = 0;
        cycle(32'h04030201, 4'b1111, 1'b0);
        cycle(32'h14131211, 4'b1111, 1'b0);
        cycle(32'h24232221, 4'b1111, 1'b0);
        chk("ovf_set", bus.OVF, 1);
        idle_cycles(8);
        chk("ovf_words", dk_words, 8);
        cycle(32'h0, 4'b0000, 1'b1);
        chk("ovf_clr", bus.OVF, 0);

        // malformed masks
        dk_words = 0;
        cycle(32'hDEADBEEF, 4'b0101, 1'b0);
        chk("err_0101", bus.ERR, 1);
        idle_cycles(3);
        chk("err_words", dk_words, 0);
        cycle(32'h0, 4'b0000, 1'b1);
        cycle(32'hCAFEF00D, 4'b0100, 1'b0);
        chk("err_dk2", bus.ERR, 1);
        cycle(32'h0, 4'b0000, 1'b1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [3:0] m;
            case ($urandom_range(0, 7))
                0, 1, 2: m = 4'b0000;
                3:       m = 4'($urandom_range(0, 15));
                default: m = legal_masks[$urandom_range(0, 3)];
            endcase
            cycle($urandom, m, ($urandom_range(0, 24) == 0));
        end
        idle_cycles(10);

        // reset during the second output word
        cycle(32'h89ABCDEF, 4'b1111, 1'b0);
        cycle(32'h0, 4'b0000, 1'b0);
        cycle(32'h0, 4'b0000, 1'b0);
        chk("mid_word2", bus.D, 8'hCD);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        dk_words = 0;
        idle_cycles(6);
        chk("mid_after_words", dk_words, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
